// File: rtl/rle_pkg.sv
// Shared definitions for the RLE readback path: mode encodings, decoder states
// and the width of the count field.
package rle_pkg;

   localparam int RLE_COUNT_W = 31;

   localparam logic [1:0] RLE_MODE_8  = 2'd0;
   localparam logic [1:0] RLE_MODE_16 = 2'd1;
   localparam logic [1:0] RLE_MODE_24 = 2'd2;
   localparam logic [1:0] RLE_MODE_32 = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2
   } rle_state_e;

endpackage

// File: rtl/rle_dec_unpack.sv
// Splits an encoded RLE word into flag, count and value fields for the
// selected word width. Purely combinational.
module rle_dec_unpack
   import rle_pkg::*;
(
   input  logic [1:0]             mode_i,
   input  logic [31:0]            data_i,
   output logic                   flag_o,
   output logic [RLE_COUNT_W-1:0] count_o,
   output logic [31:0]            value_o
);

   always_comb begin
      flag_o  = 1'b0;
      count_o = '0;
      case (mode_i)
         RLE_MODE_8: begin
            flag_o  = data_i[7];
            count_o = {24'd0, data_i[6:0]};
         end
         RLE_MODE_16: begin
            flag_o  = data_i[15];
            count_o = {16'd0, data_i[14:0]};
         end
         RLE_MODE_24: begin
            flag_o  = data_i[23];
            count_o = {8'd0, data_i[22:0]};
         end
         default: begin
            flag_o  = data_i[31];
            count_o = data_i[30:0];
         end
      endcase
      // The value field is the count field with the flag position cleared.
      value_o = {1'b0, count_o};
   end

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: expands value/count words back into one sample per clock.
// Optional RLE_DECODER_STATS_EN adds a sampleCount output transfer counter.
module rle_decoder
   import rle_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [1:0]  mode,
   input  logic        rle_repeat_mode,
   input  logic        clear,
   input  logic [31:0] dataIn,
   input  logic        validIn,
   output logic        readyIn,
   output logic [31:0] dataOut,
   output logic        validOut,
   input  logic        readyOut,
`ifdef RLE_DECODER_STATS_EN
   output logic [31:0] sampleCount,
`endif
   output logic        error
);

   rle_state_e             state_q, state_d;
   logic [31:0]            last_q, last_d;
   logic [RLE_COUNT_W-1:0] rem_q, rem_d;
   logic [31:0]            data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   error_q, error_d;

   logic                   flag;
   logic [RLE_COUNT_W-1:0] count;
   logic [31:0]            value;
   logic [RLE_COUNT_W-1:0] eff;
   logic                   slot_free;
   logic                   accept;

   rle_dec_unpack u_unpack (
      .mode_i  (mode),
      .data_i  (dataIn),
      .flag_o  (flag),
      .count_o (count),
      .value_o (value)
   );

   // In inclusive mode a zero count must not underflow into a huge run.
   assign eff = rle_repeat_mode ? ((count == '0) ? '0 : count - 31'd1) : count;

   assign slot_free = !valid_q || readyOut;
   assign readyIn   = (state_q != ST_REPEAT) && slot_free && !clear;
   assign accept    = validIn && readyIn;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      rem_d   = rem_q;
      data_d  = data_q;
      valid_d = valid_q;
      error_d = error_q;
      if (valid_q && readyOut) valid_d = 1'b0;
      if (clear) begin
         state_d = ST_EMPTY;
         rem_d   = '0;
         valid_d = 1'b0;
         error_d = 1'b0;
      end else if (state_q == ST_REPEAT) begin
         if (slot_free) begin
            data_d  = last_q;
            valid_d = 1'b1;
            rem_d   = rem_q - 31'd1;
            if (rem_q == 31'd1) state_d = ST_HOLD;
         end
      end else if (accept) begin
         if (!flag) begin
            data_d  = value;
            valid_d = 1'b1;
            last_d  = value;
            state_d = ST_HOLD;
         end else if (state_q == ST_EMPTY) begin
            error_d = 1'b1;
         end else if (eff != '0) begin
            data_d  = last_q;
            valid_d = 1'b1;
            rem_d   = eff - 31'd1;
            state_d = (eff != 31'd1) ? ST_REPEAT : ST_HOLD;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         last_q  <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   assign dataOut  = data_q;
   assign validOut = valid_q;
   assign error    = error_q;

`ifdef RLE_DECODER_STATS_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)                    cnt_d = '0;
      else if (valid_q && readyOut) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign sampleCount = cnt_q;
`endif

endmodule

// File: doc/rle_decoder.md
# rle_decoder

Expands the run-length-encoded sample stream produced by the core's RLE encoder back into one sample per clock. It sits on the readback and verification side of the capture path, fed from sample memory or a stream source. Its output is the original per-sample data stream, so benches and downstream analysis logic can compare it sample-for-sample against the capture input. Flow control is valid/ready on both sides.

## Interface
Parameters:
- none; all widths are fixed by the 32-bit sample bus and the 31-bit count field.

Ports:
- `clock`  in  1  — single clock for the whole block.
- `reset_n`  in  1  — asynchronous, active-low reset.
- `mode`  in  2  — word width: 0=8, 1=16, 2=24, 3=32 bits. The flag bit is the MSB of that width.
- `rle_repeat_mode`  in  1  — 1: the count is inclusive of the already-emitted value (effective repeats = count−1). 0: effective repeats = count.
- `clear`  in  1  — synchronous flush.
- `dataIn`  in  32  — encoded word.
- `validIn`  in  1  — input word present.
- `readyIn`  out  1  — decoder accepts a word this cycle.
- `dataOut`  out  32  — decoded sample.
- `validOut`  out  1  — sample present.
- `readyOut`  in  1  — downstream accepts the sample.
- `error`  out  1  — sticky flag: a count word arrived with no prior value.

## Operation
- **Field extraction (per `mode`):**
  - flag = `dataIn`[W−1].
  - count = `dataIn`[W−2:0], zero-extended to 31 bits.
  - value = `dataIn`[W−2:0], with the flag bit and all bits above W forced to 0.
- **State machine:**
  - EMPTY: no value held yet.
  - HOLD: last value held, no pending repeats.
  - REPEAT: pending repeats > 0.
- **Value word (flag=0), accepted in EMPTY or HOLD:**
  - Loads the output register.
  - Stores the value as `last`.
  - Goes to HOLD.
- **Count word (flag=1) in HOLD:**
  - Effective count e = 0: word is dropped, no output.
  - e ≥ 1: `last` is loaded to the output, `remaining` = e−1, next state is REPEAT if `remaining` > 0, else HOLD.
- **Count word in EMPTY:**
  - Word is dropped and `error` is set.
  - State stays EMPTY.
- **REPEAT state:**
  - Each free output slot loads `last` and decrements `remaining`.
  - When `remaining` reaches 0, the state goes to HOLD.
- **Consecutive count words:** each one extends the same `last`, so the encoder's split runs are supported.
- **`clear`:**
  - Next state EMPTY.
  - `remaining` = 0, `validOut` = 0, `error` = 0.
  - Any input word in the same cycle is ignored, and `readyIn` is forced to 0 while `clear` is asserted.
  - `clear` has priority over all other events.

## Timing
- **Reset values:** `dataOut`=0, `validOut`=0, `error`=0, state EMPTY, `remaining`=0, `last`=0.
- **Output slot free:** `!validOut || readyOut`.
- **`readyIn`:** `(state != REPEAT) && slot_free && !clear`. It is combinational from state and `readyOut`.
- **Latency:** a word accepted at edge N produces `validOut` at N+1.
  - A count with e repeats produces samples on e consecutive cycles when `readyOut` is held high.
  - `readyIn` is low for e−1 cycles.
- **Throughput:** 1 sample/clock sustained. Value words can be accepted back-to-back.
- **Backpressure:** when `validOut` && !`readyOut`, `dataOut`/`validOut` hold stable and `remaining` does not decrement.
- **Count field:** up to 2^31−1 with no saturation. In repeat mode, count=0 is treated as e=0, with no underflow.
- **Mode change:** `mode` takes effect on the next accepted word. It must change only while the block is in EMPTY or HOLD.

## Configuration
- **`RLE_DECODER_STATS_EN` defined:**
  - Adds output `sampleCount` [31:0]: number of output transfers (`validOut` && `readyOut`).
  - Wraps modulo 2^32.
  - Reset to 0 by `reset_n` and by `clear`.
- **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Shared package `rle_pkg`:**
  - Mode encoding constants: `RLE_MODE_8`/`16`/`24`/`32`.
  - State typedef with the three states.
  - Constant `RLE_COUNT_W` = 31.
- **Sub-module `rle_dec_unpack`:** combinational; from `mode` and `dataIn` it produces flag, count and value. It is shared with future readback logic.
- **Top level:** holds the FSM, the `last` register, the `remaining` counter, the output register and the optional stats counter.

## Test plan
- **Value then count:** `mode`=0, `rle_repeat_mode`=0; send 0x05, 0x83, 0x07.
  - Expect outputs 5,5,5,5,7 on consecutive cycles.
  - Expect `readyIn` low for 2 cycles after the count.
- **Repeat mode and zero count:** `rle_repeat_mode`=1, `mode`=1; send 0x1234, 0x8004, 0x8001, 0x8000.
  - Expect 0x1234 ×4.
  - The last two counts add nothing.
- **Backpressure:** `mode`=3; send 0x00000011, 0x80000005; toggle `readyOut` 1,0,0,1,…
  - Expect exactly six 0x11 transfers.
  - `dataOut` stays stable while stalled.
- **Count first:** from reset send 0x8A.
  - Expect no output and `error`=1.
  - Then 0x01 → output 1, with `error` still 1.
- **Clear mid-run:** send 0x22, 0xFF (127 repeats); pulse `clear` after 10 outputs.
  - Expect `validOut`=0 the next cycle, state EMPTY, `error`=0.
  - A following 0x33 → single 0x33.
- **Stats build (`RLE_DECODER_STATS_EN`):** after the first scenario, expect `sampleCount`=5; after `clear`, expect 0.
